// File: rtl/idex_operand_stage.sv
// -----------------------------------------------------------------------------
// idex_operand_stage
//
// ID/EX pipeline register plus the EX-side operand selector. Sits directly
// downstream of the forwarding unit. On every pipeline advance it either
// captures the decoded ID instruction or loads a bubble. A bubble is loaded on
// flush or on a load-use / unresolved branch-jr hazard. In EX the latched
// register-file operands are overridden by the forwarding unit's registered
// rs/rt data before they drive the ALU and memory stages.
//
// Optional feature (macro IDEX_STALL_CNT_EN): adds the saturating hazard stall
// counters cnt_loaduse and cnt_branch_stall.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   pipeline_ready        global advance enable (all state holds when 0)
//   flush                 discard ID instruction and EX contents
//   id_*                  decoded ID-stage operands and control
//   s_loaduse             load-use hazard from the forwarding unit
//   s_branch_jr_ok        branch/jr operands ready
//   s/d_rs_fastforward    registered rs override valid / data (EX-aligned)
//   s/d_rt_fastforward    registered rt override valid / data (EX-aligned)
//   id_stall              hold PC and IF/ID this cycle
//   ex_*                  EX-stage operands and control
//   cnt_loaduse           load-use stall count (IDEX_STALL_CNT_EN only)
//   cnt_branch_stall      branch/jr stall count (IDEX_STALL_CNT_EN only)
// -----------------------------------------------------------------------------
module idex_operand_stage #(
    parameter int                    ALU_OP_W      = 5,
    parameter logic [ALU_OP_W-1:0]   BUBBLE_ALU_OP = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 pipeline_ready,
    input  logic                 flush,
    input  logic                 id_valid,
    input  logic [31:0]          id_rs_data,
    input  logic [31:0]          id_rt_data,
    input  logic [31:0]          id_imm,
    input  logic                 id_alu_src_imm,
    input  logic [ALU_OP_W-1:0]  id_alu_op,
    input  logic [4:0]           id_reg_dst,
    input  logic                 id_reg_wen,
    input  logic                 id_mem_read,
    input  logic                 id_mem_write,
    input  logic                 s_loaduse,
    input  logic                 s_branch_jr_ok,
    input  logic                 s_rs_fastforward,
    input  logic [31:0]          d_rs_fastforward,
    input  logic                 s_rt_fastforward,
    input  logic [31:0]          d_rt_fastforward,
    output logic                 id_stall,
    output logic                 ex_valid,
    output logic [31:0]          ex_op_a,
    output logic [31:0]          ex_op_b,
    output logic [31:0]          ex_store_data,
    output logic [ALU_OP_W-1:0]  ex_alu_op,
    output logic [4:0]           ex_reg_dst,
    output logic                 ex_reg_wen,
    output logic                 ex_mem_read,
    output logic                 ex_mem_write
`ifdef IDEX_STALL_CNT_EN
    ,
    output logic [15:0]          cnt_loaduse,
    output logic [15:0]          cnt_branch_stall
`endif
);

    logic                haz;
    logic                vld_p1;
    logic                reg_wen_p1;
    logic                mem_read_p1;
    logic                mem_write_p1;
    logic                alu_src_imm_p1;
    logic [ALU_OP_W-1:0] alu_op_p1;
    logic [4:0]          reg_dst_p1;
    logic [31:0]         rs_p1;
    logic [31:0]         rt_p1;
    logic [31:0]         imm_p1;
    logic [31:0]         rs_eff;
    logic [31:0]         rt_eff;

    assign haz = id_valid & (s_loaduse | ~s_branch_jr_ok);

    // A flush wins over a hazard and must not stall, so upstream flushes too.
    assign id_stall = haz & ~flush;

    // ---- ID -> EX boundary ----
    // Bubbles clear control only; operand data holds since nothing consumes it
    // while ex_valid is low.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p1         <= 1'b0;
            reg_wen_p1     <= 1'b0;
            mem_read_p1    <= 1'b0;
            mem_write_p1   <= 1'b0;
            alu_src_imm_p1 <= 1'b0;
            alu_op_p1      <= BUBBLE_ALU_OP;
            reg_dst_p1     <= 5'd0;
            rs_p1          <= 32'd0;
            rt_p1          <= 32'd0;
            imm_p1         <= 32'd0;
        end else if (pipeline_ready) begin
            if (flush || haz) begin
                vld_p1         <= 1'b0;
                reg_wen_p1     <= 1'b0;
                mem_read_p1    <= 1'b0;
                mem_write_p1   <= 1'b0;
                alu_src_imm_p1 <= 1'b0;
                alu_op_p1      <= BUBBLE_ALU_OP;
                reg_dst_p1     <= 5'd0;
            end else begin
                vld_p1         <= id_valid;
                reg_wen_p1     <= id_reg_wen & id_valid;
                mem_read_p1    <= id_mem_read & id_valid;
                mem_write_p1   <= id_mem_write & id_valid;
                alu_src_imm_p1 <= id_alu_src_imm;
                alu_op_p1      <= id_alu_op;
                reg_dst_p1     <= id_reg_dst;
                rs_p1          <= id_rs_data;
                rt_p1          <= id_rt_data;
                imm_p1         <= id_imm;
            end
        end
    end

    // ---- EX operand selection ----
    // Forwarding data is already aligned to EX, so it overrides the latched
    // register-file values directly.
    assign rs_eff        = s_rs_fastforward ? d_rs_fastforward : rs_p1;
    assign rt_eff        = s_rt_fastforward ? d_rt_fastforward : rt_p1;
    assign ex_op_a       = rs_eff;
    assign ex_op_b       = alu_src_imm_p1 ? imm_p1 : rt_eff;
    assign ex_store_data = rt_eff;

    assign ex_valid      = vld_p1;
    assign ex_alu_op     = alu_op_p1;
    assign ex_reg_dst    = reg_dst_p1;
    assign ex_reg_wen    = reg_wen_p1;
    assign ex_mem_read   = mem_read_p1;
    assign ex_mem_write  = mem_write_p1;

`ifdef IDEX_STALL_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // Each stalled advance is charged to load-use first, otherwise to branch/jr.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_loaduse      <= 16'd0;
            cnt_branch_stall <= 16'd0;
        end else if (pipeline_ready && id_stall) begin
            if (s_loaduse)
                cnt_loaduse <= sat_inc(cnt_loaduse);
            else
                cnt_branch_stall <= sat_inc(cnt_branch_stall);
        end
    end
`endif

endmodule
